// File: rtl/fls_checker.sv
// fls_checker: scoreboard for Fibonacci-like sequences, f[n] = f[n-1] + f[n-2] mod 2^WIDTH.
// Define FLS_CHK_ERRCNT_EN to add the saturating err_cnt output.
module fls_checker #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] exp,
  output logic             run,
  output logic             mismatch,
  output logic             err,
  output logic [CNT_W-1:0] cnt
`ifdef FLS_CHK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  typedef enum logic [1:0] {S_A, S_B, S_RUN} state_t;
  state_t state;
  logic en_q, acc;
  logic [WIDTH-1:0] a, b;
  assign acc = en & ~en_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= 1'b0;
      state <= S_A;
      a <= '0;
      b <= '0;
      exp <= '0;
      run <= 1'b0;
      mismatch <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
`ifdef FLS_CHK_ERRCNT_EN
      err_cnt <= '0;
`endif
    end else begin
      en_q <= en;
      mismatch <= 1'b0;
      if (acc) begin
        cnt <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
        case (state)
          S_A: begin
            a <= d;
            state <= S_B;
          end
          S_B: begin
            b <= d;
            exp <= a + d;
            run <= 1'b1;
            state <= S_RUN;
          end
          default: begin
            if (d != exp) begin
              mismatch <= 1'b1;
              err <= 1'b1;
`ifdef FLS_CHK_ERRCNT_EN
              err_cnt <= (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
`endif
            end
            // resync to the observed term so one bad term yields one mismatch
            a <= b;
            b <= d;
            exp <= b + d;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/fls_checker.md
Name: fls_checker

Overview:
Consumer-end monitor for the Fibonacci-like sequence (FLS) generator interface (clk, rst, en, d/f).
- Watches the same button-style `en` strobe and a data bus carrying sequence terms.
- Treats the first two accepted terms as seeds, then checks every later term against f[n] = f[n-1] + f[n-2] mod 2^WIDTH.
- Flags mismatches, keeps the expected next term visible, and counts accepted terms.
- Used on-board next to `fls` and in benches as a self-checking scoreboard.

Parameters:
- WIDTH, 7, data width of the sequence terms (matches the FLS d/f bus).
- CNT_W, 8, width of the accepted-term counter and the optional error counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  level strobe; one term is accepted per 0->1 transition.
- d  input  WIDTH  term presented for checking; sampled on the accepting edge.
- exp  output  WIDTH  expected next term; valid while run=1.
- run  output  1  high once both seeds are captured.
- mismatch  output  1  one-cycle pulse: last accepted term differed from exp.
- err  output  1  sticky error flag, cleared only by rst.
- cnt  output  CNT_W  number of accepted terms, saturating.

Behaviour:
- rst is synchronous, active-high, and takes priority over everything.
- Reset values:
  - en_q=0, state=S_A, a=b=0.
  - exp=0, run=0, mismatch=0, err=0, cnt=0.
- Edge detect:
  - en_q <= en every cycle.
  - acc = en & ~en_q.
  - en held high for N cycles yields exactly one acc.
  - en high in the reset cycle is not accepted; after reset en_q=0, so en still high on the first post-reset cycle is accepted.
- All register updates happen at the rising edge where acc=1. The results are visible the following cycle (1-cycle latency).
- Default on every cycle: mismatch <= 0.
- State S_A (waiting for first seed), on acc:
  - a <= d, cnt++, go to S_B.
- State S_B (waiting for second seed), on acc:
  - b <= d, exp <= a + d (mod 2^WIDTH), run <= 1, cnt++, go to S_RUN.
- State S_RUN, on acc:
  - Compare d with exp.
  - If equal: no error action.
  - If not equal: mismatch <= 1, err <= 1.
  - In both cases resync to the observed value: a <= b, b <= d, exp <= b + d mod 2^WIDTH, cnt++.
  - One bad term therefore produces one mismatch, not a cascade.
- Arithmetic: WIDTH-bit addition, carry discarded (wrap-around).
- cnt saturates at 2^CNT_W - 1 and never wraps.
- Without acc, all state holds. d is ignored when acc=0.
- A reset mid-run returns to S_A, drops run, and clears err/cnt. The seed sequence restarts.

Optional Feature:
- Macro FLS_CHK_ERRCNT_EN.
- When defined: adds output port err_cnt (CNT_W bits).
  - Reset value 0.
  - Increments on every mismatch, saturating at 2^CNT_W - 1.
- When undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
1. Nominal sequence.
   - rst 7 cycles, then accept d=02, 03 (en pulses of 5+ cycles each).
   - Expect run=1, exp=05, cnt=2.
   - Accept 05, 08, 0D: expect exp=08, 0D, 15, err=0, mismatch never high, cnt=5.
2. Mismatch and resync.
   - Seeds 02, 03, then d=05, then d=09 (expected 08).
   - Expect a single 1-cycle mismatch, err=1 sticky, exp=0E (05+09).
   - Next d=0E gives no mismatch; err stays 1.
   - With FLS_CHK_ERRCNT_EN, err_cnt=1.
3. Held en.
   - Hold en=1 for 25 cycles with d=02.
   - Expect cnt=1 and state S_B; no second acceptance until en returns to 0 and rises again.
4. Wrap-around.
   - Seeds 64 (0x40), 50 (0x32).
   - Expect exp=0x72. Accepting 0x72 gives exp = 0x32 + 0x72 = 0xA4 mod 0x80 = 0x24.
5. Reset mid-run.
   - After scenario 2, assert rst one cycle.
   - Expect run=0, err=0, mismatch=0, cnt=0, exp=0.
   - Seeds 04, 05 then give exp=09.
6. Counter saturation.
   - Set CNT_W=3 and accept 10 correct terms.
   - Expect cnt=7 held, no wrap, no error.
